// File: rtl/reg_cmd_pkg.sv
// Shared FunSel encodings, command op and FSM state types for reg_cmd_driver.
package reg_cmd_pkg;

    localparam logic [1:0] FS_DEC   = 2'b00;
    localparam logic [1:0] FS_INC   = 2'b01;
    localparam logic [1:0] FS_LOAD  = 2'b10;
    localparam logic [1:0] FS_CLEAR = 2'b11;

    // Op encoding is identical to FunSel so the latched op drives the register directly.
    typedef enum logic [1:0] {
        OpDec   = FS_DEC,
        OpInc   = FS_INC,
        OpLoad  = FS_LOAD,
        OpClear = FS_CLEAR
    } cmd_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StSettle
    } state_e;

    function automatic logic op_is_repeat(input logic [1:0] op);
        return (op == FS_DEC) || (op == FS_INC);
    endfunction

endpackage

// File: rtl/reg_shadow_model.sv
// Shadow copy of the driven register; flags a sticky mismatch when the observed
// Q disagrees with the tracked value at command completion.
module reg_shadow_model
    import reg_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_hs,
    input  cmd_op_e          i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_check,
    input  logic [WIDTH-1:0] i_reg_q,
    output logic             o_mismatch
);

    logic [WIDTH-1:0] r_shadow;
    logic             r_shadow_valid;
    logic             r_mismatch;
    logic [WIDTH-1:0] w_count_ext;

    assign w_count_ext = WIDTH'(i_count);
    assign o_mismatch  = r_mismatch;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_mismatch     <= 1'b0;
        end else begin
            if (i_hs) begin
                unique case (i_op)
                    OpLoad: begin
                        r_shadow       <= i_data;
                        r_shadow_valid <= 1'b1;
                    end
                    OpClear: begin
                        r_shadow       <= '0;
                        r_shadow_valid <= 1'b1;
                    end
                    OpInc:   r_shadow <= r_shadow + w_count_ext;
                    OpDec:   r_shadow <= r_shadow - w_count_ext;
                    default: r_shadow <= r_shadow;
                endcase
            end
            // Sticky until reset; only meaningful once a LOAD/CLEAR anchored the shadow.
            if (i_check && r_shadow_valid && (i_reg_q != r_shadow)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_cmd_driver.sv
// Expands load/clear/inc-N/dec-N commands into per-cycle E/FunSel pulses for a register.
// Defining REG_CMD_SHADOW_EN adds a shadow model that drives the sticky mismatch flag.
module reg_cmd_driver
    import reg_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             reg_E,
    output logic [1:0]       reg_FunSel,
    output logic [WIDTH-1:0] reg_In,
    input  logic [WIDTH-1:0] reg_Q,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mismatch
);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_ready, w_ready_next;
    logic             r_e, w_e_next;
    cmd_op_e          r_funsel, w_funsel_next;
    logic [WIDTH-1:0] r_in, w_in_next;
    logic             r_done, w_done_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic             w_hs;

    assign w_hs = cmd_valid && r_ready;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_ready_next  = r_ready;
        w_e_next      = r_e;
        w_funsel_next = r_funsel;
        w_in_next     = r_in;
        w_done_next   = 1'b0;
        w_result_next = r_result;
        case (r_state)
            StIdle: begin
                if (w_hs) begin
                    w_funsel_next = cmd_op_e'(cmd_op);
                    w_in_next     = cmd_data;
                    w_ready_next  = 1'b0;
                    if (!op_is_repeat(cmd_op)) begin
                        w_cnt_next   = CNT_W'(1);
                        w_e_next     = 1'b1;
                        w_state_next = StIssue;
                    end else if (cmd_count == '0) begin
                        w_cnt_next   = '0;
                        w_state_next = StSettle;
                    end else begin
                        w_cnt_next   = cmd_count;
                        w_e_next     = 1'b1;
                        w_state_next = StIssue;
                    end
                end
            end
            StIssue: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_e_next     = 1'b0;
                    w_state_next = StSettle;
                end
            end
            StSettle: begin
                // Register has absorbed the last pulse by now; capture and reopen.
                w_result_next = reg_Q;
                w_done_next   = 1'b1;
                w_ready_next  = 1'b1;
                w_state_next  = StIdle;
            end
            default: begin
                w_e_next     = 1'b0;
                w_ready_next = 1'b1;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_e      <= 1'b0;
            r_funsel <= OpDec;
            r_in     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_ready  <= w_ready_next;
            r_e      <= w_e_next;
            r_funsel <= w_funsel_next;
            r_in     <= w_in_next;
            r_done   <= w_done_next;
            r_result <= w_result_next;
        end
    end

    assign cmd_ready  = r_ready;
    assign reg_E      = r_e;
    assign reg_FunSel = r_funsel;
    assign reg_In     = r_in;
    assign done       = r_done;
    assign result     = r_result;

`ifdef REG_CMD_SHADOW_EN
    reg_shadow_model #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shadow (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_hs       (w_hs),
        .i_op       (cmd_op_e'(cmd_op)),
        .i_data     (cmd_data),
        .i_count    (cmd_count),
        .i_check    (r_state == StSettle),
        .i_reg_q    (reg_Q),
        .o_mismatch (mismatch)
    );
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_reg_cmd_driver.sv
// Bench for reg_cmd_driver: behavioural register plus command-level reference model.
module tb_reg_cmd_driver;
    import reg_cmd_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_data = '0;
    logic [7:0]  cmd_count = '0;
    logic        reg_E;
    logic [1:0]  reg_FunSel;
    logic [15:0] reg_In;
    logic [15:0] reg_Q;
    logic        done;
    logic [15:0] result;
    logic        mismatch;

    logic [15:0] r_model_q = '0;
    logic        inject = 1'b0;
    logic [1:0]  nxt_op = 2'b00;
    logic [15:0] nxt_data = '0;
    logic [7:0]  nxt_count = '0;
    logic [15:0] exp_q = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    // Plain register: not reset by the driver's reset, so applied ops survive it.
    always @(posedge clock) begin
        if (reg_E) begin
            case (reg_FunSel)
                2'b00: r_model_q <= r_model_q - 16'd1;
                2'b01: r_model_q <= r_model_q + 16'd1;
                2'b10: r_model_q <= reg_In;
                default: r_model_q <= 16'h0000;
            endcase
        end
    end
    assign reg_Q = r_model_q + {15'b0, inject};

    reg_cmd_driver #(
        .WIDTH (16),
        .CNT_W (8)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .reg_E      (reg_E),
        .reg_FunSel (reg_FunSel),
        .reg_In     (reg_In),
        .reg_Q      (reg_Q),
        .done       (done),
        .result     (result),
        .mismatch   (mismatch)
    );

    function automatic logic [15:0] model_next(input logic [1:0] op, input logic [15:0] data,
                                               input logic [7:0] count, input logic [15:0] cur);
        case (op)
            2'b10:   return data;
            2'b11:   return 16'h0000;
            2'b01:   return cur + 16'(count);
            default: return cur - 16'(count);
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        cmd_valid = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Drives one command from a negedge and returns measurements at the negedge done is seen.
    task automatic send(input logic [1:0] op, input logic [15:0] data, input logic [7:0] count,
                        input logic hold, output int wait_cyc, output int lat, output int e_cnt,
                        output int pulse_err, output int rdy_low, output logic [15:0] res,
                        output logic tmo);
        wait_cyc = 0; lat = 0; e_cnt = 0; pulse_err = 0; rdy_low = 0; res = '0; tmo = 1'b1;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = count;
        while (!cmd_ready && wait_cyc < 50) begin
            @(negedge clock);
            wait_cyc++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        if (hold) begin
            cmd_op = nxt_op; cmd_data = nxt_data; cmd_count = nxt_count;
        end else begin
            cmd_valid = 1'b0;
            cmd_op = 2'($urandom); cmd_data = 16'($urandom); cmd_count = 8'($urandom);
        end
        for (int j = 0; j < 300; j++) begin
            @(negedge clock);
            if (reg_E) begin
                if (j != e_cnt || reg_FunSel !== op || reg_In !== data) pulse_err++;
                e_cnt++;
            end
            if (!cmd_ready) rdy_low++;
            if (done) begin
                lat = j; res = result; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        n_tests++; if (reg_E !== 1'b0) begin n_fail++; $display("FAIL rst_e: got %b want 0", reg_E); end
        n_tests++; if (reg_FunSel !== 2'b00) begin n_fail++; $display("FAIL rst_funsel: got %b want 00", reg_FunSel); end
        n_tests++; if (reg_In !== 16'h0) begin n_fail++; $display("FAIL rst_in: got %h want 0000", reg_In); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_tests++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_result: got %h want 0000", result); end
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rst_mismatch: got %b want 0", mismatch); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_load();
        int w, l, e, p, r; logic [15:0] res; logic t;
        send(FS_LOAD, 16'h1234, 8'd0, 1'b0, w, l, e, p, r, res, t);
        exp_q = model_next(FS_LOAD, 16'h1234, 8'd0, exp_q);
        n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL load_timeout: got %b want 0", t); end
        n_tests++; if (e != 1) begin n_fail++; $display("FAIL load_pulses: got %0d want 1", e); end
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL load_pulse_fields: got %0d bad want 0", p); end
        n_tests++; if (l != 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", l); end
        n_tests++; if (res !== exp_q) begin n_fail++; $display("FAIL load_result: got %h want %h", res, exp_q); end
        @(negedge clock);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse: got %b want 0", done); end
        n_tests++; if (result !== exp_q) begin n_fail++; $display("FAIL load_result_hold: got %h want %h", result, exp_q); end
    endtask

    task automatic test_increment();
        int w, l, e, p, r; logic [15:0] res; logic t;
        send(FS_LOAD, 16'h1234, 8'd0, 1'b0, w, l, e, p, r, res, t);
        exp_q = model_next(FS_LOAD, 16'h1234, 8'd0, exp_q);
        send(FS_INC, 16'hABCD, 8'd3, 1'b0, w, l, e, p, r, res, t);
        exp_q = model_next(FS_INC, 16'hABCD, 8'd3, exp_q);
        n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL inc_timeout: got %b want 0", t); end
        n_tests++; if (e != 3) begin n_fail++; $display("FAIL inc_pulses: got %0d want 3", e); end
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL inc_pulse_fields: got %0d bad want 0", p); end
        n_tests++; if (r != 4) begin n_fail++; $display("FAIL inc_ready_low: got %0d want 4", r); end
        n_tests++; if (l != 4) begin n_fail++; $display("FAIL inc_latency: got %0d want 4", l); end
        n_tests++; if (res !== 16'h1237) begin n_fail++; $display("FAIL inc_result: got %h want 1237", res); end
    endtask

    task automatic test_wrap();
        int w, l, e, p, r; logic [15:0] res; logic t;
        send(FS_LOAD, 16'hFFFE, 8'd0, 1'b0, w, l, e, p, r, res, t);
        send(FS_INC, 16'h0, 8'd3, 1'b0, w, l, e, p, r, res, t);
        n_tests++; if (res !== 16'h0001) begin n_fail++; $display("FAIL wrap_inc: got %h want 0001", res); end
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL wrap_mismatch: got %b want 0", mismatch); end
        send(FS_CLEAR, 16'h5555, 8'd0, 1'b0, w, l, e, p, r, res, t);
        send(FS_DEC, 16'h0, 8'd2, 1'b0, w, l, e, p, r, res, t);
        exp_q = 16'hFFFE;
        n_tests++; if (res !== exp_q) begin n_fail++; $display("FAIL wrap_dec: got %h want %h", res, exp_q); end
        n_tests++; if (e != 2) begin n_fail++; $display("FAIL wrap_dec_pulses: got %0d want 2", e); end
    endtask

    task automatic test_zero_count();
        int w, l, e, p, r; logic [15:0] res; logic t;
        send(FS_DEC, 16'h9999, 8'd0, 1'b0, w, l, e, p, r, res, t);
        n_tests++; if (t !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got %b want 0", t); end
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL zero_pulses: got %0d want 0", e); end
        n_tests++; if (l != 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", l); end
        n_tests++; if (res !== exp_q) begin n_fail++; $display("FAIL zero_result: got %h want %h", res, exp_q); end
    endtask

    task automatic test_back_to_back();
        int w, l, e, p, r; logic [15:0] res; logic t;
        nxt_op = FS_LOAD; nxt_data = 16'h00FF; nxt_count = 8'd0;
        send(FS_CLEAR, 16'h1111, 8'd0, 1'b1, w, l, e, p, r, res, t);
        n_tests++; if (res !== 16'h0000) begin n_fail++; $display("FAIL b2b_clear: got %h want 0000", res); end
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL b2b_clear_fields: got %0d bad want 0", p); end
        send(FS_LOAD, 16'h00FF, 8'd0, 1'b0, w, l, e, p, r, res, t);
        exp_q = 16'h00FF;
        n_tests++; if (w != 0) begin n_fail++; $display("FAIL b2b_wait: got %0d want 0", w); end
        n_tests++; if (l != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", l); end
        n_tests++; if (res !== exp_q) begin n_fail++; $display("FAIL b2b_load: got %h want %h", res, exp_q); end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = FS_INC; cmd_count = 8'd5; cmd_data = 16'h0;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        n_tests++; if (reg_E !== 1'b0) begin n_fail++; $display("FAIL midrst_e: got %b want 0", reg_E); end
        repeat (2) begin
            @(negedge clock);
            if (done) seen_done++;
        end
        reset_n = 1'b1;
        @(negedge clock);
        if (done) seen_done++;
        exp_q = exp_q + 16'd2;
        n_tests++; if (seen_done != 0) begin n_fail++; $display("FAIL midrst_done: got %0d want 0", seen_done); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
        n_tests++; if (reg_E !== 1'b0) begin n_fail++; $display("FAIL midrst_e_after: got %b want 0", reg_E); end
        n_tests++; if (r_model_q !== exp_q) begin n_fail++; $display("FAIL midrst_applied: got %h want %h", r_model_q, exp_q); end
    endtask

    task automatic test_random();
        int w, l, e, p, r; logic [15:0] res; logic t;
        logic [1:0] op; logic [15:0] d; logic [7:0] c; int exp_n;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom); d = 16'($urandom); c = 8'($urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send(op, d, c, 1'b0, w, l, e, p, r, res, t);
            exp_q = model_next(op, d, c, exp_q);
            exp_n = op[1] ? 1 : int'(c);
            n_tests++;
            if (t !== 1'b0 || res !== exp_q || e != exp_n || l != exp_n + 1 || p != 0) begin
                n_fail++;
                $display("FAIL rand_cmd%0d op=%b cnt=%0d: got res=%h n=%0d lat=%0d bad=%0d tmo=%b want res=%h n=%0d lat=%0d",
                         i, op, c, res, e, l, p, t, exp_q, exp_n, exp_n + 1);
            end
        end
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rand_mismatch: got %b want 0", mismatch); end
    endtask

`ifdef REG_CMD_SHADOW_EN
    task automatic test_shadow();
        int w, l, e, p, r; logic [15:0] res; logic t;
        send(FS_LOAD, 16'h4321, 8'd0, 1'b0, w, l, e, p, r, res, t);
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL shadow_clean: got %b want 0", mismatch); end
        inject = 1'b1;
        send(FS_INC, 16'h0, 8'd1, 1'b0, w, l, e, p, r, res, t);
        n_tests++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL shadow_detect: got %b want 1", mismatch); end
        inject = 1'b0;
        send(FS_CLEAR, 16'h0, 8'd0, 1'b0, w, l, e, p, r, res, t);
        exp_q = 16'h0000;
        n_tests++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL shadow_sticky: got %b want 1", mismatch); end
        apply_reset();
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL shadow_reset: got %b want 0", mismatch); end
    endtask
`else
    task automatic test_shadow();
        int w, l, e, p, r; logic [15:0] res; logic t;
        send(FS_LOAD, 16'h4321, 8'd0, 1'b0, w, l, e, p, r, res, t);
        inject = 1'b1;
        send(FS_INC, 16'h0, 8'd1, 1'b0, w, l, e, p, r, res, t);
        inject = 1'b0;
        exp_q = 16'h4322;
        n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL shadow_off: got %b want 0", mismatch); end
        n_tests++; if (res !== 16'h4323) begin n_fail++; $display("FAIL shadow_off_result: got %h want 4323", res); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_increment();
        test_wrap();
        test_zero_count();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_shadow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
